// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its downstream decimation stage.
package fir_pkg;
  localparam int DEF_DATA_W = 8;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  // An accumulator of data_w + decim_log2 bits holds 2^decim_log2 samples without overflow.
  function automatic int acc_w(input int data_w, input int decim_log2);
    return data_w + decim_log2;
  endfunction
endpackage

// File: rtl/fir_decim_buffer_if.sv
// Output stream of the decimation buffer: FWFT head, valid/ready handshake, occupancy.
interface fir_decim_buffer_if
  import fir_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FIFO_AW = 3
);
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [FIFO_AW:0]         count;

  modport master (output out_data, out_valid, count, input out_ready);
  modport slave  (input out_data, out_valid, count, output out_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; a push at full is accepted only alongside a pop.
module sync_fifo_fwft #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic          drop,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fir_decim_buffer.sv
// Block-average decimator (rounded, round half up) feeding a FWFT FIFO with a sticky drop flag.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_AW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     clear_ovf,
  output logic                     overflow,
  fir_decim_buffer_if.master       bus
);
  localparam int ACC_W = acc_w(DATA_W, DECIM_LOG2);
  localparam int PH_W  = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam int LAST  = (1 << DECIM_LOG2) - 1;
  localparam int RND   = (1 << DECIM_LOG2) >> 1;

  logic signed [ACC_W-1:0]  acc_p0;
  logic [PH_W-1:0]          phase_p0;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] result;
  logic                     group_end;
  logic                     push_vld;
  logic                     fifo_drop;
  logic [DATA_W-1:0]        head;

  // Sum + 2^(L-1) stays inside ACC_W bits even at the extremes, so no saturation.
  function automatic logic signed [DATA_W-1:0] round_avg(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] t;
    t = (s + ACC_W'(RND)) >>> DECIM_LOG2;
    return t[DATA_W-1:0];
  endfunction

  assign sum       = acc_p0 + ACC_W'(in);
  assign group_end = (phase_p0 == PH_W'(LAST));
  assign push_vld  = en && group_end;
  assign result    = round_avg(sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0   <= '0;
      phase_p0 <= '0;
    end else if (en) begin
      if (group_end) begin
        acc_p0   <= '0;
        phase_p0 <= '0;
      end else begin
        acc_p0   <= sum;
        phase_p0 <= phase_p0 + 1'b1;
      end
    end
  end

  // Setting the flag takes priority over a clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  sync_fifo_fwft #(
    .W  (DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_vld),
    .push_data (result),
    .pop       (bus.out_ready),
    .head      (head),
    .valid     (bus.out_valid),
    .drop      (fifo_drop),
    .count     (bus.count)
  );

  assign bus.out_data = head;
endmodule
